// File: rtl/cpu_pkg.sv
// Shared types for the five-stage MIPS core: write kinds, reset PC, writeback entry.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

  localparam int unsigned CPU_DW = 32;
  localparam int unsigned CPU_AW = 5;

  localparam logic [CPU_DW-1:0] PC_RESET_DEFAULT = 32'h0000_3000;

  // How the memory-stage instruction wants to use the GRF write port.
  typedef enum logic [1:0] {
    WK_NONE = 2'b00,
    WK_NORM = 2'b01,
    WK_MOVZ = 2'b10,
    WK_MOVN = 2'b11
  } wk_t;

  // One registered writeback slot; addr/data are zero whenever we is low.
  typedef struct packed {
    logic              we;
    logic [CPU_AW-1:0] addr;
    logic [CPU_DW-1:0] data;
    logic [CPU_DW-1:0] pc;
  } wb_entry_t;

endpackage

// File: rtl/cond_eval.sv
// Resolves whether a memory-stage instruction really writes the GRF (movz/movn aware).
// Latency: purely combinational.
// Backpressure: none; callers decide when the result is consumed.
module cond_eval
  import cpu_pkg::*;
#(
  parameter int unsigned DW = 32,
  parameter int unsigned AW = 5
) (
  input  logic          valid_i,
  input  wk_t           kind_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] cond_i,
  output logic          wr_ok_o,
  output logic          we_next_o
);

  logic wr_ok;

  // Kind-specific write condition; moves test the rt operand against zero.
  always_comb begin
    wr_ok = 1'b0;
    unique case (kind_i)
      WK_NORM: wr_ok = 1'b1;
      WK_MOVZ: wr_ok = (cond_i == '0);
      WK_MOVN: wr_ok = (cond_i != '0);
      default: wr_ok = 1'b0;
    endcase
  end

  assign wr_ok_o   = wr_ok;
  // $0 is hardwired to zero, so a write there is never issued.
  assign we_next_o = valid_i & wr_ok & (addr_i != '0);

endmodule

// File: rtl/cond_wb_stage.sv
// MEM->WB pipeline register that resolves movz/movn on capture and drives GRF + forwarding.
// Latency: one cycle; all outputs come straight from registers.
// Backpressure: stall holds everything (counters too); flush loads a bubble and beats stall.
module cond_wb_stage
  import cpu_pkg::*;
#(
  parameter int unsigned      DW       = 32,
  parameter int unsigned      AW       = 5,
  parameter logic [DW-1:0]    PC_RESET = PC_RESET_DEFAULT
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          m_valid,
  input  logic [1:0]    m_kind,
  input  logic [AW-1:0] m_addr,
  input  logic [DW-1:0] m_data,
  input  logic [DW-1:0] m_cond,
  input  logic [DW-1:0] m_pc,
  input  logic          stall,
  input  logic          flush,
  output logic          grf_we,
  output logic [AW-1:0] grf_waddr,
  output logic [DW-1:0] grf_wdata,
  output logic [DW-1:0] w_pc,
  output logic          fwd_valid,
  output logic [AW-1:0] fwd_addr,
  output logic [DW-1:0] fwd_data,
  output logic [31:0]   retire_cnt,
  output logic [31:0]   supp_cnt
);

  // The entry struct is sized for the core's fixed 32-bit datapath / 5-bit register index.
  wb_entry_t   wb_q, wb_d;
  logic [31:0] retire_cnt_q, retire_cnt_d;
  logic [31:0] supp_cnt_q, supp_cnt_d;

  logic        wr_ok;
  logic        we_next;
  wk_t         kind;

  assign kind = wk_t'(m_kind);

  cond_eval #(
    .DW (DW),
    .AW (AW)
  ) u_cond_eval (
    .valid_i   (m_valid),
    .kind_i    (kind),
    .addr_i    (m_addr),
    .cond_i    (m_cond),
    .wr_ok_o   (wr_ok),
    .we_next_o (we_next)
  );

  // Next-state selection: flush bubble, stall hold, otherwise capture the memory stage.
  always_comb begin
    wb_d         = wb_q;
    retire_cnt_d = retire_cnt_q;
    supp_cnt_d   = supp_cnt_q;
    if (flush) begin
      wb_d.we   = 1'b0;
      wb_d.addr = '0;
      wb_d.data = '0;
      wb_d.pc   = m_pc;
    end else if (!stall) begin
      // Zeroing addr/data when no write issues keeps the forwarding bus clean for consumers.
      wb_d.we   = we_next;
      wb_d.addr = we_next ? m_addr : '0;
      wb_d.data = we_next ? m_data : '0;
      wb_d.pc   = m_pc;
      if (m_valid) begin
        retire_cnt_d = retire_cnt_q + 32'd1;
        // A move whose condition failed still retires, but is also counted as suppressed.
        if (((kind == WK_MOVZ) || (kind == WK_MOVN)) && !wr_ok) begin
          supp_cnt_d = supp_cnt_q + 32'd1;
        end
      end
    end
  end

  // Stage register and counters with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wb_q.we      <= 1'b0;
      wb_q.addr    <= '0;
      wb_q.data    <= '0;
      wb_q.pc      <= PC_RESET;
      retire_cnt_q <= '0;
      supp_cnt_q   <= '0;
    end else begin
      wb_q         <= wb_d;
      retire_cnt_q <= retire_cnt_d;
      supp_cnt_q   <= supp_cnt_d;
    end
  end

  assign grf_we     = wb_q.we;
  assign grf_waddr  = wb_q.addr;
  assign grf_wdata  = wb_q.data;
  assign w_pc       = wb_q.pc;
  assign fwd_valid  = wb_q.we;
  assign fwd_addr   = wb_q.addr;
  assign fwd_data   = wb_q.data;
  assign retire_cnt = retire_cnt_q;
  assign supp_cnt   = supp_cnt_q;

endmodule

// File: tb/tb_cond_wb_stage.sv
// Randomized + directed bench for cond_wb_stage against a behavioural model.
// Model updates on each rising edge from the rules; outputs compared on every falling edge.
// Directed literal checks pin the model on the hand-computed scenarios.
module tb_cond_wb_stage;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        m_valid;
  logic [1:0]  m_kind;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  logic [31:0] m_cond;
  logic [31:0] m_pc;
  logic        stall;
  logic        flush;
  logic        grf_we;
  logic [4:0]  grf_waddr;
  logic [31:0] grf_wdata;
  logic [31:0] w_pc;
  logic        fwd_valid;
  logic [4:0]  fwd_addr;
  logic [31:0] fwd_data;
  logic [31:0] retire_cnt;
  logic [31:0] supp_cnt;

  int n_chk  = 0;
  int n_pass = 0;

  // behavioural model state
  bit          known  = 1'b0;
  bit          cmp_en = 1'b1;
  logic        e_we;
  logic [4:0]  e_addr;
  logic [31:0] e_data;
  logic [31:0] e_pc;
  logic [31:0] e_ret;
  logic [31:0] e_sup;

  cond_wb_stage dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .m_valid    (m_valid),
    .m_kind     (m_kind),
    .m_addr     (m_addr),
    .m_data     (m_data),
    .m_cond     (m_cond),
    .m_pc       (m_pc),
    .stall      (stall),
    .flush      (flush),
    .grf_we     (grf_we),
    .grf_waddr  (grf_waddr),
    .grf_wdata  (grf_wdata),
    .w_pc       (w_pc),
    .fwd_valid  (fwd_valid),
    .fwd_addr   (fwd_addr),
    .fwd_data   (fwd_data),
    .retire_cnt (retire_cnt),
    .supp_cnt   (supp_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic bit cond_ok(input logic [1:0] k, input logic [31:0] c);
    if (k == 2'b01) return 1'b1;
    if (k == 2'b10) return c == 0;
    if (k == 2'b11) return c != 0;
    return 1'b0;
  endfunction

  // Model: apply the stage rules at each rising edge from the inputs present there.
  always @(posedge clk) begin
    bit w;
    if (!reset_n) begin
      e_we = 0; e_addr = 0; e_data = 0; e_pc = 32'h0000_3000; e_ret = 0; e_sup = 0;
      known = 1'b1;
    end else if (flush) begin
      e_we = 0; e_addr = 0; e_data = 0; e_pc = m_pc;
    end else if (!stall) begin
      w      = m_valid && cond_ok(m_kind, m_cond) && (m_addr != 0);
      e_we   = w;
      e_addr = w ? m_addr : 5'd0;
      e_data = w ? m_data : 32'd0;
      e_pc   = m_pc;
      if (m_valid) begin
        e_ret = e_ret + 1;
        if (m_kind[1] && !cond_ok(m_kind, m_cond)) e_sup = e_sup + 1;
      end
    end
  end

  // Compare every falling edge once the model is defined.
  always @(negedge clk) begin
    if (known && cmp_en) begin
      chk("grf_we",     {31'd0, grf_we},    {31'd0, e_we});
      chk("grf_waddr",  {27'd0, grf_waddr}, {27'd0, e_addr});
      chk("grf_wdata",  grf_wdata,          e_data);
      chk("w_pc",       w_pc,               e_pc);
      chk("fwd_valid",  {31'd0, fwd_valid}, {31'd0, e_we});
      chk("fwd_addr",   {27'd0, fwd_addr},  {27'd0, e_addr});
      chk("fwd_data",   fwd_data,           e_data);
      chk("retire_cnt", retire_cnt,         e_ret);
      chk("supp_cnt",   supp_cnt,           e_sup);
    end
  end

  task automatic rand_inputs();
    m_valid = ($urandom_range(0, 3) != 0);
    m_kind  = 2'($urandom_range(0, 3));
    m_addr  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
    m_data  = $urandom;
    m_cond  = ($urandom_range(0, 1) == 0) ? 32'd0 : $urandom;
    m_pc    = $urandom & 32'hFFFF_FFFC;
  endtask

  task automatic set_in(input logic [1:0] k, input logic [4:0] a, input logic [31:0] d,
                        input logic [31:0] c, input logic [31:0] pc);
    m_valid = 1'b1; m_kind = k; m_addr = a; m_data = d; m_cond = c; m_pc = pc;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset held two cycles with random inputs and random stall/flush.
    reset_n = 1'b0;
    stall   = 1'($urandom_range(0, 1));
    flush   = 1'($urandom_range(0, 1));
    rand_inputs();
    repeat (2) begin
      cyc();
      rand_inputs();
      stall = 1'($urandom_range(0, 1));
      flush = 1'($urandom_range(0, 1));
    end
    chk("rst grf_we",     {31'd0, grf_we}, 32'd0);
    chk("rst grf_wdata",  grf_wdata,       32'd0);
    chk("rst fwd_valid",  {31'd0, fwd_valid}, 32'd0);
    chk("rst w_pc",       w_pc,            32'h0000_3000);
    chk("rst retire_cnt", retire_cnt,      32'd0);
    chk("rst supp_cnt",   supp_cnt,        32'd0);

    // MOVZ taken.
    reset_n = 1'b1; stall = 1'b0; flush = 1'b0;
    set_in(2'b10, 5'd8, 32'h1234_5678, 32'd0, 32'h0000_3004);
    cyc();
    chk("movz grf_we",     {31'd0, grf_we},     32'd1);
    chk("movz grf_waddr",  {27'd0, grf_waddr},  32'd8);
    chk("movz grf_wdata",  grf_wdata,           32'h1234_5678);
    chk("movz w_pc",       w_pc,                32'h0000_3004);
    chk("movz retire_cnt", retire_cnt,          32'd1);
    chk("movz supp_cnt",   supp_cnt,            32'd0);

    // MOVN suppressed.
    set_in(2'b11, 5'd9, 32'hDEAD_BEEF, 32'd0, 32'h0000_3008);
    cyc();
    chk("movn grf_we",     {31'd0, grf_we},    32'd0);
    chk("movn grf_waddr",  {27'd0, grf_waddr}, 32'd0);
    chk("movn grf_wdata",  grf_wdata,          32'd0);
    chk("movn supp_cnt",   supp_cnt,           32'd1);
    chk("movn retire_cnt", retire_cnt,         32'd2);

    // Normal write to $0 is dropped but still retires.
    set_in(2'b01, 5'd0, 32'hFFFF_FFFF, 32'h5, 32'h0000_300C);
    cyc();
    chk("r0 grf_we",     {31'd0, grf_we}, 32'd0);
    chk("r0 grf_wdata",  grf_wdata,       32'd0);
    chk("r0 retire_cnt", retire_cnt,      32'd3);

    // Capture $5 = 7, then stall three cycles with changing inputs.
    set_in(2'b01, 5'd5, 32'd7, 32'd0, 32'h0000_3010);
    cyc();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_inputs();
      cyc();
      chk("stall grf_we",     {31'd0, grf_we},    32'd1);
      chk("stall grf_waddr",  {27'd0, grf_waddr}, 32'd5);
      chk("stall grf_wdata",  grf_wdata,          32'd7);
      chk("stall w_pc",       w_pc,               32'h0000_3010);
      chk("stall retire_cnt", retire_cnt,         32'd4);
    end
    // stall + flush together: flush wins.
    flush = 1'b1;
    set_in(2'b01, 5'd6, 32'd9, 32'd0, 32'h0000_3020);
    cyc();
    chk("flush grf_we",     {31'd0, grf_we}, 32'd0);
    chk("flush grf_wdata",  grf_wdata,       32'd0);
    chk("flush w_pc",       w_pc,            32'h0000_3020);
    chk("flush retire_cnt", retire_cnt,      32'd4);

    // Randomized traffic with occasional stall, flush and reset.
    for (int i = 0; i < 400; i++) begin
      rand_inputs();
      stall   = ($urandom_range(0, 4) == 0);
      flush   = ($urandom_range(0, 7) == 0);
      reset_n = ($urandom_range(0, 59) != 0);
      cyc();
    end

    // Counter wrap: preload retire count during a stall, then capture one instruction.
    reset_n = 1'b1; flush = 1'b0; stall = 1'b1;
    rand_inputs();
    cmp_en = 1'b0;
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    e_ret = 32'hFFFF_FFFF;
    @(posedge clk);
    #1;
    release dut.retire_cnt_q;
    @(negedge clk);
    cmp_en = 1'b1;
    chk("wrap preload", retire_cnt, 32'hFFFF_FFFF);
    stall = 1'b0;
    rand_inputs();
    m_valid = 1'b1;
    cyc();
    chk("wrap retire_cnt", retire_cnt, 32'd0);
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/cond_wb_stage.md
# cond_wb_stage

Memory-to-writeback pipeline stage for the five-stage MIPS core. It registers the instruction leaving the memory stage and resolves conditional moves (`movz`, `movn`) at capture time. It then drives the general register file (GRF) write port and the writeback forwarding bus from registered state only. It also keeps retire and suppressed-move counters for the testbench and debug.

## Interface
Parameters:
- `DW`, 32: data and PC width.
- `AW`, 5: register address width.
- `PC_RESET`, 32'h0000_3000: value of `w_pc` after reset.

Ports:
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: synchronous, active-low reset. One clock; reset is synchronous and active-low.
- `m_valid` in 1: memory-stage slot holds a real instruction.
- `m_kind` in 2: write kind, `WK_NONE`=00, `WK_NORM`=01, `WK_MOVZ`=10, `WK_MOVN`=11.
- `m_addr` in AW: destination register.
- `m_data` in DW: result to write (rs value for moves).
- `m_cond` in DW: condition operand (rt value for moves; ignored otherwise).
- `m_pc` in DW: PC of the memory-stage instruction.
- `stall` in 1: hold stage contents.
- `flush` in 1: load a bubble.
- `grf_we` out 1: GRF write enable.
- `grf_waddr` out AW: GRF write address.
- `grf_wdata` out DW: GRF write data.
- `w_pc` out DW: PC of the writeback instruction.
- `fwd_valid` out 1: forwarding entry valid; equals `grf_we`.
- `fwd_addr` out AW: forwarding register address.
- `fwd_data` out DW: forwarding data.
- `retire_cnt` out 32: count of valid instructions loaded.
- `supp_cnt` out 32: count of moves whose condition failed.

## Operation
- Write condition `wr_ok` is computed combinationally from the memory-stage inputs:
  - `WK_NORM`: 1.
  - `WK_MOVZ`: `m_cond == 0`.
  - `WK_MOVN`: `m_cond != 0`.
  - `WK_NONE`: 0.
- Final `we_next = m_valid & wr_ok & (m_addr != 0)`. Writes to `$0` are never issued.
- On capture, the stage stores `we_next`, `m_pc`, the address and the data.
  - Address is stored as `we_next ? m_addr : 0`.
  - Data is stored as `we_next ? m_data : 0`.
  - Outputs are therefore zero whenever no write is issued.
- Load priority per rising edge, highest first:
  - `!reset_n`: reset.
  - `flush`: load a bubble (we=0, addr=0, data=0, `w_pc` ← `m_pc`).
  - `stall`: hold all state.
  - Otherwise: capture the memory stage.
- When `flush` and `stall` are both high, `flush` wins.
- `retire_cnt` increments on a capture edge (not reset, not flush, not stall) with `m_valid=1`.
- `supp_cnt` increments on the same capture edges when `m_valid=1`, `m_kind` is MOVZ or MOVN, and the condition fails.
- A suppressed move still counts toward `retire_cnt`.
- Both counters wrap modulo 2^32.
- The `fwd_*` outputs mirror the `grf_*` outputs exactly.

## Timing
- Latency is one cycle: the inputs at edge N are visible on the outputs after edge N. All outputs come directly from registers.
- Reset values: `grf_we`=0, `grf_waddr`=0, `grf_wdata`=0, `fwd_*`=0, `w_pc`=`PC_RESET`, `retire_cnt`=0, `supp_cnt`=0.
- Reset during a stall or flush takes effect on that edge. Reset overrides everything.
- During a stall the outputs hold. A held `grf_we`=1 rewrites the same value, which is harmless. Counters do not advance while stalled.
- The condition is evaluated only on the capture edge. Changes to `m_cond` while stalled have no effect on the held entry.
- No state machine is used. State is the stage register plus two counters.

## Structure
- Package `cpu_pkg` holds:
  - the `wk_t` 2-bit enum (`WK_NONE`, `WK_NORM`, `WK_MOVZ`, `WK_MOVN`);
  - the `PC_RESET` default;
  - a `wb_entry_t` struct with fields `we`, `addr`, `data`, `pc`.
- Sub-module `cond_eval` is a combinational block that produces `we_next` from `m_valid`, `m_kind`, `m_addr` and `m_cond`. The decode stage reuses it for hazard prediction.

## Test plan
- Reset: hold `reset_n`=0 for 2 cycles with random inputs. Expected: all outputs 0, `w_pc`=32'h3000. Counters stay 0.
- MOVZ taken: `m_kind`=MOVZ, `m_addr`=8, `m_data`=32'h1234_5678, `m_cond`=0. Expected next cycle: `grf_we`=1, `grf_waddr`=8, `grf_wdata`=32'h1234_5678, `retire_cnt`=1, `supp_cnt`=0.
- MOVN suppressed: `m_kind`=MOVN, `m_addr`=9, `m_data`=32'hDEAD_BEEF, `m_cond`=0. Expected: `grf_we`=0, `grf_waddr`=0, `grf_wdata`=0, `supp_cnt`=1.
- `$0` write: `WK_NORM`, `m_addr`=0, `m_data`=32'hFFFF_FFFF. Expected: `grf_we`=0, `retire_cnt` increments.
- Stall then flush:
  - Capture a NORM write to `$5`=7.
  - Assert `stall` for 3 cycles while changing the inputs. Expected: outputs hold, counters unchanged.
  - Assert `stall`+`flush` together. Expected: bubble, `grf_we`=0.
- Counter wrap: force `retire_cnt` to 32'hFFFF_FFFF, then capture one valid instruction. Expected: `retire_cnt`=0.
